// File: rtl/if_stage.sv
// ============================================================================
// IfStage : instruction-fetch stage of the RV32I pipeline.
//
// Owns the architectural fetch PC, issues reads on the instruction-memory
// port and fills the IF/ID buffer. It also accepts redirects from the execute
// stage, which closes the branch loop.
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   pcmux_sel       redirect select from execute (00/11 none, 01 alu_out,
//                   10 alu_out with bit 0 cleared)
//   alu_out         redirect target from execute
//   stall           IF/ID buffer must hold its contents
//   imem_address    fetch address (registered)
//   imem_read       read request (registered)
//   imem_rdata      returned instruction word
//   imem_resp       one-cycle completion strobe for the current read
//   if_valid        IF/ID slot holds a real instruction
//   if_pc           PC of the IF/ID instruction
//   if_instr        IF/ID instruction word (NOP when the slot is invalid)
// ============================================================================
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h4000_0060,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  pcmux_sel,
    input  logic [31:0] alu_out,
    input  logic        stall,
    output logic [31:0] imem_address,
    output logic        imem_read,
    input  logic [31:0] imem_rdata,
    input  logic        imem_resp,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr
);

    // REQ: a read is (or is about to be) on the memory port.
    // HOLD: a response arrived while the IF/ID buffer was stalled; it waits
    // in the skid registers and no new read is issued.
    typedef enum logic {
        REQ  = 1'b0,
        HOLD = 1'b1
    } state_e;

    state_e      state_q;
    logic [31:0] fetch_pc_q;
    logic [31:0] pend_pc_q;
    logic [31:0] skid_pc_q;
    logic [31:0] skid_instr_q;
    logic        drop_q;
    logic        read_q;
    logic        if_valid_q;
    logic [31:0] if_pc_q;
    logic [31:0] if_instr_q;

    logic        redirect;
    logic [31:0] target;
    logic        resp;

    // Decode the execute-stage redirect. Select 11 is reserved and behaves
    // like "no redirect"; select 10 clears bit 0 (JALR-style target).
    always_comb begin
        redirect = (pcmux_sel == 2'b01) || (pcmux_sel == 2'b10);
        target   = (pcmux_sel == 2'b10) ? (alu_out & 32'hFFFF_FFFE) : alu_out;
    end

    // A response only counts while our read request is actually asserted;
    // this ignores any stray strobe in the cycle right after reset.
    assign resp = imem_resp & read_q;

    // The memory port is driven purely from registers, so no input can reach
    // imem_address/imem_read combinationally.
    assign imem_address = fetch_pc_q;
    assign imem_read    = read_q;

    assign if_valid = if_valid_q;
    assign if_pc    = if_pc_q;
    assign if_instr = if_instr_q;

    // Fetch FSM and IF/ID buffer.
    // Priority is redirect > response > stall. A redirect while a read is in
    // flight cannot move the address (the memory needs it stable), so the
    // target is parked in pend_pc_q and the in-flight response is dropped
    // when it arrives. A later redirect simply overwrites pend_pc_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= REQ;
            fetch_pc_q   <= RESET_PC;
            pend_pc_q    <= RESET_PC;
            skid_pc_q    <= RESET_PC;
            skid_instr_q <= NOP_INSTR;
            drop_q       <= 1'b0;
            read_q       <= 1'b0;
            if_valid_q   <= 1'b0;
            if_pc_q      <= RESET_PC;
            if_instr_q   <= NOP_INSTR;
        end else begin
            case (state_q)
                REQ: begin
                    if (redirect) begin
                        if_valid_q <= 1'b0;
                        if_instr_q <= NOP_INSTR;
                        read_q     <= 1'b1;
                        if (resp || !read_q) begin
                            fetch_pc_q <= target;
                            drop_q     <= 1'b0;
                        end else begin
                            pend_pc_q <= target;
                            drop_q    <= 1'b1;
                        end
                    end else if (resp && drop_q) begin
                        drop_q     <= 1'b0;
                        fetch_pc_q <= pend_pc_q;
                        read_q     <= 1'b1;
                        if (!stall) begin
                            if_valid_q <= 1'b0;
                            if_instr_q <= NOP_INSTR;
                        end
                    end else if (resp && !stall) begin
                        if_valid_q <= 1'b1;
                        if_pc_q    <= fetch_pc_q;
                        if_instr_q <= imem_rdata;
                        fetch_pc_q <= fetch_pc_q + 32'd4;
                        read_q     <= 1'b1;
                    end else if (resp) begin
                        skid_pc_q    <= fetch_pc_q;
                        skid_instr_q <= imem_rdata;
                        fetch_pc_q   <= fetch_pc_q + 32'd4;
                        read_q       <= 1'b0;
                        state_q      <= HOLD;
                    end else begin
                        read_q <= 1'b1;
                        if (!stall) begin
                            if_valid_q <= 1'b0;
                            if_instr_q <= NOP_INSTR;
                        end
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        if_valid_q <= 1'b0;
                        if_instr_q <= NOP_INSTR;
                        fetch_pc_q <= target;
                        read_q     <= 1'b1;
                        state_q    <= REQ;
                    end else if (!stall) begin
                        if_valid_q <= 1'b1;
                        if_pc_q    <= skid_pc_q;
                        if_instr_q <= skid_instr_q;
                        read_q     <= 1'b1;
                        state_q    <= REQ;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the RV32I pipeline; it closes the branch loop with the execute stage.
- Owns the architectural PC, drives the instruction-memory read port and fills the IF/ID buffer.
- Each cycle it consumes the execute stage's pcmux_sel and alu_out redirect. On a redirect it flushes, and it discards any fetch that was already in flight.

Parameters:
- RESET_PC, 32'h4000_0060: PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013: instruction word presented when the output slot is invalid (addi x0,x0,0).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- pcmux_sel  input  2  redirect select from execute: 00 pc_plus4 (no redirect), 01 alu_out, 10 alu_mod2, 11 reserved (treated as 00).
- alu_out  input  32  redirect target from execute.
- stall  input  1  IF/ID buffer must hold (hazard or downstream stall).
- imem_address  output  32  fetch address.
- imem_read  output  1  read request.
- imem_rdata  input  32  returned instruction.
- imem_resp  input  1  one-cycle completion strobe for the current read.
- if_valid  output  1  IF/ID slot holds a real instruction.
- if_pc  output  32  PC of the IF/ID instruction.
- if_instr  output  32  IF/ID instruction word.

Behaviour:
- Reset (async, held while rst=1):
  - fetch_pc=RESET_PC; state=REQ; drop=0.
  - imem_read=0; imem_address=RESET_PC.
  - if_valid=0; if_pc=RESET_PC; if_instr=NOP_INSTR.
  - imem_read first rises in the first clock edge after rst falls.
- Redirect:
  - redirect = (pcmux_sel==01) | (pcmux_sel==10).
  - target = alu_out for 01; alu_out & 32'hFFFF_FFFE for 10.
- State REQ:
  - Drives imem_read=1 and imem_address=fetch_pc. The address must stay stable until imem_resp.
  - resp & !drop & !redirect & !stall: if_valid<=1, if_pc<=fetch_pc, if_instr<=imem_rdata; fetch_pc<=fetch_pc+4 (wraps modulo 2^32); stay in REQ. Throughput is 1 instr/cycle with a zero-wait memory.
  - resp & !drop & !redirect & stall: skid_pc<=fetch_pc, skid_instr<=imem_rdata; fetch_pc<=fetch_pc+4; go to HOLD. if_* registers are unchanged.
  - resp & drop: discard rdata; drop<=0; fetch_pc<=pend_pc; stay in REQ.
  - redirect & resp: discard rdata; fetch_pc<=target; drop<=0.
  - redirect & !resp: pend_pc<=target; drop<=1. The address is held; the in-flight read completes and is then discarded.
  - A later redirect while drop=1 overwrites pend_pc (the youngest redirect wins).
- State HOLD:
  - imem_read=0.
  - !stall: if_* <= skid contents with if_valid=1; go to REQ.
  - redirect: discard skid; fetch_pc<=target; go to REQ. Redirect overrides stall release.
- Flush:
  - Any redirect forces if_valid<=0 and if_instr<=NOP_INSTR on the next edge, even when stall=1.
  - if_pc is don't-care while if_valid=0.
- Stall with no new data:
  - if_* hold while stall=1. No redirect is pending in this case.
  - With stall=0 and no accepted response, if_valid<=0 (bubble).
- Priority: rst > redirect > resp > stall.
- No combinational path exists from imem_rdata, imem_resp or pcmux_sel to the imem_* outputs; imem_* are driven from registered state only.

Test Plan:
1. Reset release, zero-wait memory returning addr^32'hA5A5_0000 → if_pc sequence 4000_0060, 4000_0064, 4000_0068 on consecutive cycles; if_valid=1 from the 2nd edge.
2. 3-cycle memory latency → imem_address holds 4000_0060 for 3 cycles with imem_read=1; one if_valid pulse per response; bubbles in between.
3. stall=1 for 4 cycles while a response arrives at 4000_0064 → if_* frozen, HOLD entered with imem_read=0; after release if_pc=4000_0064, then fetch of 4000_0068.
4. pcmux_sel=01, alu_out=4000_0100 with no read outstanding → next edge if_valid=0; the next fetch address is 4000_0100.
5. pcmux_sel=10, alu_out=4000_0203 while a 2-cycle read of 4000_0070 is outstanding → imem_address stays 4000_0070 until resp; its data is never presented; the next request goes to 4000_0202.
6. Redirect coinciding with resp and stall=1, followed by rst pulsed mid-read → response dropped and if_valid=0; rst returns all outputs to reset values immediately; fetch restarts at RESET_PC.
